serial_cba_adder: RTL and testbench

Multi-cycle, digit-serial 32-bit two's-complement adder with a start/done handshake. It is the area-reduced sequential counterpart of the combinational carry-bypass adder on the chip, with the same result contract: sum, carry-out and signed overflow. It processes DIGIT bits per clock, LSB digit first, using one DIGIT-wide carry-bypass slice and a carry register. It sits behind the chip's operand registers and is driven by the arithmetic controller or the bench.

---
 rtl/serial_cba_adder_if.sv | 25 ++
 rtl/serial_cba_adder.sv | 133 +++++++++++++
 tb/tb_serial_cba_adder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_cba_adder_if.sv
// Start/done handshake and operand/result bundle for the digit-serial adder.
// The controller holds the master side and the adder holds the slave side.
interface serial_cba_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             of;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, of
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, of
    );
endinterface

// File: rtl/serial_cba_adder.sv
// Digit-serial two's-complement adder: one DIGIT-wide carry-bypass slice reused
// over WIDTH/DIGIT cycles, LSB digit first, results published only at completion.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one digit per edge through the slice; last digit publishes result
module serial_cba_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_cba_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic             a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, of_q, of_d, done_q, done_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             slice_co;
    logic [WIDTH-1:0] acc_next;

    assign dig_a = a_q[DIGIT-1:0];
    assign dig_b = b_q[DIGIT-1:0];

    // Ripple inside the slice; when every bit propagates, the incoming carry
    // bypasses the chain straight to the slice carry-out.
    always_comb begin : slice
        logic [DIGIT:0] c;
        c     = '0;
        dig_s = '0;
        c[0]  = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dig_s[i] = dig_a[i] ^ dig_b[i] ^ c[i];
            c[i+1]   = (dig_a[i] & dig_b[i]) | ((dig_a[i] ^ dig_b[i]) & c[i]);
        end
        slice_co = (&(dig_a ^ dig_b)) ? carry_q : c[DIGIT];
    end

    // New digit enters at the top so the last digit lands the sum in place.
    assign acc_next = WIDTH'({dig_s, acc_q} >> DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            of_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            of_q     <= of_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        of_d     = of_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    a_sign_d = bus.a[WIDTH-1];
                    b_sign_d = bus.b[WIDTH-1];
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_next;
                carry_d = slice_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = acc_next;
                    cout_d  = slice_co;
                    of_d    = (a_sign_q == b_sign_q) && (acc_next[WIDTH-1] != a_sign_q);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.of   = of_q;
endmodule

// File: tb/tb_serial_cba_adder.sv
// Directed and random adds against a plain-arithmetic reference, checking
// latency, busy/done timing, output stability and the reset abort.
module tb_serial_cba_adder;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_cba_adder_if #(.WIDTH(32)) ifc ();

    serial_cba_adder #(.WIDTH(32), .DIGIT(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_sum  = '0;
    logic        prev_cout = 1'b0;
    logic        prev_of   = 1'b0;

    // {of, cout, sum} from integer arithmetic on the operands
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
        logic [63:0] u;
        longint      s;
        logic        o;
        u = 64'(a) + 64'(b) + 64'(c);
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(64'(c));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {o, u[32], u[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c);
        ifc.a     = a;
        ifc.b     = b;
        ifc.cin   = c;
        ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    // Entered at the negedge following the accepting edge.
    task automatic collect(input logic [31:0] ea, input logic [31:0] eb, input logic ec,
                           input string tag, input bit clr_start);
        logic [33:0] exp;
        int          cyc;
        exp = model(ea, eb, ec);
        cyc = 0;
        chk({tag, ":busy_first"}, 64'(ifc.busy), 64'd1);
        chk({tag, ":done_first"}, 64'(ifc.done), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (clr_start) ifc.start = 1'b0;
            cyc++;
            if (ifc.done) break;
            chk({tag, ":busy"}, 64'(ifc.busy), 64'd1);
            chk({tag, ":hold"}, {31'b0, ifc.of, ifc.cout, ifc.sum},
                {31'b0, prev_of, prev_cout, prev_sum});
        end
        chk({tag, ":latency"}, 64'(cyc), 64'(N));
        chk({tag, ":done"}, 64'(ifc.done), 64'd1);
        chk({tag, ":busy_end"}, 64'(ifc.busy), 64'd0);
        chk({tag, ":sum"}, 64'(ifc.sum), 64'(exp[31:0]));
        chk({tag, ":cout"}, 64'(ifc.cout), 64'(exp[32]));
        chk({tag, ":of"}, 64'(ifc.of), 64'(exp[33]));
        prev_sum  = exp[31:0];
        prev_cout = exp[32];
        prev_of   = exp[33];
        @(posedge clk);
        @(negedge clk);
        chk({tag, ":done_pulse"}, 64'(ifc.done), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.cin   = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        chk("rst:busy", 64'(ifc.busy), 64'd0);
        chk("rst:done", 64'(ifc.done), 64'd0);
        chk("rst:outs", {31'b0, ifc.of, ifc.cout, ifc.sum}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        collect(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, "max_pos", 1'b1);
        chk("max_pos:const", {31'b0, ifc.of, ifc.cout, ifc.sum}, {31'b0, 2'b10, 32'hFFFFFFFE});

        issue(32'h80000000, 32'hFFFFFFFF, 1'b0);
        collect(32'h80000000, 32'hFFFFFFFF, 1'b0, "min_neg", 1'b1);
        chk("min_neg:const", {31'b0, ifc.of, ifc.cout, ifc.sum}, {31'b0, 2'b11, 32'h7FFFFFFF});

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        collect(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "neg_one", 1'b1);
        chk("neg_one:const", {31'b0, ifc.of, ifc.cout, ifc.sum}, {31'b0, 2'b01, 32'hFFFFFFFE});

        issue(32'h12345678, 32'h12345670, 1'b1);
        collect(32'h12345678, 32'h12345670, 1'b1, "cin", 1'b1);
        chk("cin:const", {31'b0, ifc.of, ifc.cout, ifc.sum}, {31'b0, 2'b00, 32'h2468ACE9});

        // second start while busy must be ignored
        issue(32'h00000123, 32'h00000123, 1'b0);
        ifc.a     = 32'hFFFFF999;
        ifc.b     = 32'h00000111;
        ifc.start = 1'b1;
        collect(32'h00000123, 32'h00000123, 1'b0, "ignore", 1'b1);
        chk("ignore:const", 64'(ifc.sum), 64'h246);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("ignore:no_queue", {62'b0, ifc.busy, ifc.done}, 64'd0);
        end

        // back-to-back: start held through the done cycle
        ifc.a     = 32'h00000420;
        ifc.b     = 32'h00000420;
        ifc.cin   = 1'b1;
        ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.a     = 32'hFFFFF999;
        ifc.b     = 32'h00000111;
        ifc.cin   = 1'b0;
        collect(32'h00000420, 32'h00000420, 1'b1, "b2b1", 1'b0);
        ifc.start = 1'b0;
        chk("b2b1:const", 64'(prev_sum), 64'h841);
        collect(32'hFFFFF999, 32'h00000111, 1'b0, "b2b2", 1'b1);
        chk("b2b2:const", {31'b0, ifc.of, ifc.cout, ifc.sum}, {31'b0, 2'b00, 32'hFFFFFAAA});

        // reset in the middle of an add
        issue(32'h0F0F0F0F, 32'h01010101, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort:outs", {29'b0, ifc.busy, ifc.done, ifc.of, ifc.cout, ifc.sum}, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_of   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort:idle", {29'b0, ifc.busy, ifc.done, ifc.of, ifc.cout, ifc.sum}, 64'd0);
        end
        issue(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        collect(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, "after_abort", 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ~ra : $urandom;
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc);
            collect(ra, rb, rc, "rand", 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
